// File: rtl/quad_7seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : quad_7seg_scan_ctrl
// Brief    : 14-bit binary to 4-digit BCD (double-dabble) with multiplexed
//            7-segment scan, leading-zero blanking and overflow dashes.
// Revision : 1.0
// ============================================================================
module quad_7seg_scan_ctrl #(
    parameter int SCAN_DIV       = 27000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1,
    parameter int BLANK_LZ       = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] value,
    input  logic        value_valid,
    output logic        value_ready,
    output logic        busy,
    output logic [15:0] bcd_out,
    output logic        overflow,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  dig_en
);

    localparam int              c_PRE_W   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(SCAN_DIV - 1);
    localparam logic [6:0]      c_SEG_RST = (SEG_ACTIVE_LOW != 0) ? ~7'h3F : 7'h3F;
    localparam logic [3:0]      c_DIG_RST = (DIG_ACTIVE_LOW != 0) ? ~4'b0001 : 4'b0001;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_COMMIT  = 2'd2
    } state_t;

    state_t               r_state;
    logic [13:0]          r_shreg;
    logic [19:0]          r_acc;
    logic [3:0]           r_bitcnt;
    logic [15:0]          r_bcd;
    logic                 r_ovf;
    logic [c_PRE_W-1:0]   r_pre;
    logic [1:0]           r_idx;
    logic [6:0]           r_seg;
    logic [3:0]           r_dig;

    logic [15:0]          w_adj_lo;
    logic [19:0]          w_acc_next;
    logic [3:0]           w_digit;
    logic [15:0]          w_upper;
    logic                 w_blank;
    logic [6:0]           w_seg_raw;
    logic [3:0]           w_dig_raw;

    // Inputs never exceed 16383, so the top nibble stays <= 1 and needs no add-3.
    for (genvar i = 0; i < 4; i++) begin : g_adj
        assign w_adj_lo[4*i +: 4] = (r_acc[4*i +: 4] >= 4'd5) ? (r_acc[4*i +: 4] + 4'd3)
                                                              : r_acc[4*i +: 4];
    end

    assign w_acc_next = {r_acc[18:16], w_adj_lo, r_shreg[13]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_shreg  <= '0;
            r_acc    <= '0;
            r_bitcnt <= '0;
            r_bcd    <= '0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (value_valid) begin
                        r_shreg  <= value;
                        r_acc    <= '0;
                        r_bitcnt <= '0;
                        r_state  <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    r_acc    <= w_acc_next;
                    r_shreg  <= {r_shreg[12:0], 1'b0};
                    r_bitcnt <= r_bitcnt + 4'd1;
                    if (r_bitcnt == 4'd13) begin
                        r_state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    if (r_acc[19:16] != 4'd0) begin
                        r_bcd <= 16'h9999;
                        r_ovf <= 1'b1;
                    end else begin
                        r_bcd <= r_acc[15:0];
                        r_ovf <= 1'b0;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pre <= '0;
            r_idx <= 2'd0;
        end else if (r_pre == c_PRE_MAX) begin
            r_pre <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    assign w_digit = r_bcd[{r_idx, 2'b00} +: 4];
    assign w_upper = r_bcd >> {r_idx, 2'b00};
    assign w_blank = (BLANK_LZ != 0) && (r_idx != 2'd0) && (w_upper == 16'd0);

    always_comb begin
        w_seg_raw = 7'h00;
        w_dig_raw = 4'b0000;
        if (r_ovf) begin
            w_seg_raw = 7'h40;
            w_dig_raw = 4'b0001 << r_idx;
        end else if (!w_blank) begin
            w_dig_raw = 4'b0001 << r_idx;
            case (w_digit)
                4'd0:    w_seg_raw = 7'h3F;
                4'd1:    w_seg_raw = 7'h06;
                4'd2:    w_seg_raw = 7'h5B;
                4'd3:    w_seg_raw = 7'h4F;
                4'd4:    w_seg_raw = 7'h66;
                4'd5:    w_seg_raw = 7'h6D;
                4'd6:    w_seg_raw = 7'h7D;
                4'd7:    w_seg_raw = 7'h07;
                4'd8:    w_seg_raw = 7'h7F;
                4'd9:    w_seg_raw = 7'h6F;
                default: w_seg_raw = 7'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seg <= c_SEG_RST;
            r_dig <= c_DIG_RST;
        end else begin
            r_seg <= (SEG_ACTIVE_LOW != 0) ? ~w_seg_raw : w_seg_raw;
            r_dig <= (DIG_ACTIVE_LOW != 0) ? ~w_dig_raw : w_dig_raw;
        end
    end

    assign value_ready = rst_n && (r_state == S_IDLE);
    assign busy        = rst_n && (r_state != S_IDLE);
    assign bcd_out     = r_bcd;
    assign overflow    = r_ovf;
    assign seg         = r_seg;
    assign dig_en      = r_dig;
    assign dp          = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

endmodule
`default_nettype wire

// File: doc/quad_7seg_scan_ctrl.md
Name: quad_7seg_scan_ctrl

Overview:
Sequencing controller for the quad 7-segment display path. Accepts a 14-bit binary value over a valid/ready handshake and converts it to 4-digit BCD with an iterative shift-add-3 (double-dabble) datapath, one bit per clock. It commits the result to a display register and time-multiplexes the four digits with leading-zero blanking and overflow indication. It sits between application logic producing binary counts and the board's segment/digit pins.

Parameters:
SCAN_DIV, 27000, clocks per digit slot (27 MHz -> ~1 kHz digit rate); legal range is 2 or more.
SEG_ACTIVE_LOW, 1, when 1 the seg and dp outputs are inverted (0 = lit).
DIG_ACTIVE_LOW, 1, when 1 dig_en is inverted (0 = digit enabled).
BLANK_LZ, 1, when 1 leading zeros are blanked.

Ports:
clk  input  1  system clock.
rst_n  input  1  reset.
value  input  14  binary value to display; sampled only on accept.
value_valid  input  1  producer has a value.
value_ready  output  1  controller can accept a value (IDLE).
busy  output  1  conversion in progress; equals ~value_ready while rst_n=1.
bcd_out  output  16  committed BCD, ones digit in bits [3:0].
overflow  output  1  committed value exceeded 9999.
seg  output  7  segments gfedcba; seg[0]=a.
dp  output  1  decimal point; always inactive.
dig_en  output  4  digit enables; bit0 = ones (rightmost).

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset (rst_n low at a clk edge):
  - state=IDLE, bcd_out=0, overflow=0, display register=0, prescaler=0, digit index=0.
  - While rst_n=0: value_ready=0, busy=0.
  - After release: value_ready=1, and the display shows "0" on digit0.
- Reset mid-conversion aborts the conversion. The committed display returns to its reset value.
- FSM states:
  - IDLE: value_ready=1. Accept occurs on an edge with value_valid && value_ready. On accept, latch value into the shift register, clear the 20-bit BCD accumulator, bit count=0, and go to CONVERT.
  - CONVERT: each edge adds 3 to every accumulator nibble >=5, then shifts {acc,shreg} left by 1. After the 14th shift, go to COMMIT.
  - COMMIT: one edge. If acc>9999: bcd_out=16'h9999, overflow=1; else bcd_out=acc[15:0], overflow=0. Load the display register and return to IDLE.
- Latency: accept on edge k; shifts on edges k+1..k+14; commit on edge k+15. value_ready is low for exactly 15 cycles after edge k and high again after edge k+15.
- Changes on value or value_valid during CONVERT/COMMIT are ignored. Back-to-back accepts are allowed on the first IDLE cycle.
- Scanning:
  - The prescaler counts 0..SCAN_DIV-1 continuously and is independent of the FSM.
  - At terminal count it wraps to 0 and the digit index increments mod 4 (3 -> 0).
  - dig_en is one-hot on the digit index, polarity per DIG_ACTIVE_LOW.
  - seg shows the selected digit of the display register.
  - A commit takes effect on the next cycle's seg value without resetting the scan.
- Encoding (gfedcba, active-high before polarity):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F; dash=40.
- Blanking: with BLANK_LZ=1 and overflow=0, digit i (i>0) is blanked if it and all higher digits are zero. Blanked means dig_en inactive and seg all off. Digit0 is never blanked.
- Overflow: when overflow=1 all four digits are enabled and show a dash.
- Outputs seg and dig_en are registered, one cycle after the index/display change. They are glitch-free: exactly one or zero digits are active in any cycle.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release -> bcd_out=0x0000, overflow=0, value_ready=1, dig_en selects digit0 only, seg shows "0" (3F before polarity); digits 1-3 inactive.
- Convert 9999 with SCAN_DIV=4: accept at edge k -> value_ready low for 15 cycles; bcd_out=0x9999 after edge k+15; dig_en rotates 0->1->2->3->0 every 4 cycles; seg shows 6F on every digit.
- Convert 243 (0xF3) -> bcd_out=0x0243; digit3 blanked; digits 2/1/0 show 5B/66/4F. With BLANK_LZ=0, digit3 shows 3F.
- Convert 12000 -> overflow=1, bcd_out=0x9999, all four digits show 40. Then converting 5 -> overflow=0, only digit0 lit with 6D.
- Hold value_valid=1 with value changing every cycle -> accepts occur only at edges where value_ready=1, 16 cycles apart; each commit matches the value sampled at its accept edge.
- Assert rst_n=0 at CONVERT shift 7 of value 9999 -> on the next edge all state returns to reset values; no commit occurs; after release value_ready=1 and bcd_out=0.
